// File: rtl/cpu_alu_pkg.sv
// Shared types and constants for the ALU arbiter slice.
package cpu_alu_pkg;

    localparam int ALU_CTRL_W = 4;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational integer ALU; unknown op codes yield a zero result.
module cpu_alu
    import cpu_alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]       operand_a_i,
    input  logic [XLEN-1:0]       operand_b_i,
    input  logic [ALU_CTRL_W-1:0] control_i,
    output logic [XLEN-1:0]       result_o,
    output logic                  zero_o,
    output logic                  less_than_o,
    output logic                  unsigned_less_than_o
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;

    assign shamt                = operand_b_i[SHW-1:0];
    assign less_than_o          = $signed(operand_a_i) < $signed(operand_b_i);
    assign unsigned_less_than_o = operand_a_i < operand_b_i;
    assign zero_o               = (result_o == '0);

    // Operation decode; flags above are independent of the op code.
    always_comb begin
        result_o = '0;
        case (control_i)
            ALU_ADD:  result_o = operand_a_i + operand_b_i;
            ALU_SUB:  result_o = operand_a_i - operand_b_i;
            ALU_AND:  result_o = operand_a_i & operand_b_i;
            ALU_OR:   result_o = operand_a_i | operand_b_i;
            ALU_XOR:  result_o = operand_a_i ^ operand_b_i;
            ALU_SLL:  result_o = operand_a_i << shamt;
            ALU_SRL:  result_o = operand_a_i >> shamt;
            ALU_SRA:  result_o = $signed(operand_a_i) >>> shamt;
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, less_than_o};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, unsigned_less_than_o};
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/cpu_alu_arbiter.sv
// Round-robin arbiter sharing one cpu_alu between NUM_REQ requesters.
module cpu_alu_arbiter
    import cpu_alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_REQ = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*XLEN-1:0]      req_operand_a,
    input  logic [NUM_REQ*XLEN-1:0]      req_operand_b,
    input  logic [NUM_REQ*ALU_CTRL_W-1:0] req_control,
    output logic [NUM_REQ-1:0]           rsp_valid,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic [XLEN-1:0]              rsp_result,
    output logic                         rsp_zero,
    output logic                         rsp_less_than,
    output logic                         rsp_unsigned_less_than,
    output logic                         busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t                state_q;
    logic [IDX_W-1:0]      last_grant_q;
    logic [IDX_W-1:0]      owner_q;
    logic [XLEN-1:0]       op_a_q;
    logic [XLEN-1:0]       op_b_q;
    logic [ALU_CTRL_W-1:0] ctrl_q;
    logic [XLEN-1:0]       res_q;
    logic                  zero_q;
    logic                  lt_q;
    logic                  ult_q;
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic                  busy_q;

    logic [XLEN-1:0]       opa_arr [NUM_REQ];
    logic [XLEN-1:0]       opb_arr [NUM_REQ];
    logic [ALU_CTRL_W-1:0] ctl_arr [NUM_REQ];

    logic [IDX_W-1:0]      winner;
    logic [IDX_W-1:0]      cand;
    logic                  found;
    logic                  accept;

    logic [XLEN-1:0]       alu_result;
    logic                  alu_zero;
    logic                  alu_lt;
    logic                  alu_ult;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign opa_arr[g] = req_operand_a[g*XLEN +: XLEN];
        assign opb_arr[g] = req_operand_b[g*XLEN +: XLEN];
        assign ctl_arr[g] = req_control[g*ALU_CTRL_W +: ALU_CTRL_W];
    end

    // Round-robin pick: first valid requester after last_grant, with wrap.
    always_comb begin
        found  = 1'b0;
        winner = last_grant_q;
        cand   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(last_grant_q) + k) % 32'(NUM_REQ));
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Grant only in IDLE and never while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == IDLE) && found) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign accept = |req_ready;

    cpu_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .operand_a_i          (op_a_q),
        .operand_b_i          (op_b_q),
        .control_i            (ctrl_q),
        .result_o             (alu_result),
        .zero_o               (alu_zero),
        .less_than_o          (alu_lt),
        .unsigned_less_than_o (alu_ult)
    );

    // Control FSM with operand capture, response capture and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            owner_q      <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            ctrl_q       <= '0;
            res_q        <= '0;
            zero_q       <= 1'b0;
            lt_q         <= 1'b0;
            ult_q        <= 1'b0;
            rsp_valid_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_a_q       <= opa_arr[winner];
                        op_b_q       <= opb_arr[winner];
                        ctrl_q       <= ctl_arr[winner];
                        owner_q      <= winner;
                        last_grant_q <= winner;
                        busy_q       <= 1'b1;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    res_q       <= alu_result;
                    zero_q      <= alu_zero;
                    lt_q        <= alu_lt;
                    ult_q       <= alu_ult;
                    rsp_valid_q <= NUM_REQ'(1) << owner_q;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready[owner_q]) begin
                        rsp_valid_q <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid              = rsp_valid_q;
    assign rsp_result             = res_q;
    assign rsp_zero               = zero_q;
    assign rsp_less_than          = lt_q;
    assign rsp_unsigned_less_than = ult_q;
    assign busy                   = busy_q;

endmodule

// File: tb/tb_cpu_alu_arbiter.sv
// Bench for cpu_alu_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_cpu_alu_arbiter;
    import cpu_alu_pkg::*;

    localparam int N  = 4;
    localparam int XW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*XW-1:0] req_operand_a;
    logic [N*XW-1:0] req_operand_b;
    logic [N*4-1:0]  req_control;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [XW-1:0]   rsp_result;
    logic            rsp_zero;
    logic            rsp_less_than;
    logic            rsp_unsigned_less_than;
    logic            busy;

    logic [31:0] a_arr [N];
    logic [31:0] b_arr [N];
    logic [3:0]  c_arr [N];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_operand_a = '0;
        req_operand_b = '0;
        req_control   = '0;
        for (int i = 0; i < N; i++) begin
            req_operand_a[i*XW +: XW] = a_arr[i];
            req_operand_b[i*XW +: XW] = b_arr[i];
            req_control[i*4 +: 4]     = c_arr[i];
        end
    end

    cpu_alu_arbiter #(
        .XLEN    (XW),
        .NUM_REQ (N)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .req_valid              (req_valid),
        .req_ready              (req_ready),
        .req_operand_a          (req_operand_a),
        .req_operand_b          (req_operand_b),
        .req_control            (req_control),
        .rsp_valid              (rsp_valid),
        .rsp_ready              (rsp_ready),
        .rsp_result             (rsp_result),
        .rsp_zero               (rsp_zero),
        .rsp_less_than          (rsp_less_than),
        .rsp_unsigned_less_than (rsp_unsigned_less_than),
        .busy                   (busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic void alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic z, output logic lt, output logic ult);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << sh;
            4'd6: r = a >> sh;
            4'd7: r = $signed(a) >>> sh;
            4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        z   = (r == 32'd0);
        lt  = $signed(a) < $signed(b);
        ult = a < b;
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    bit          m_init     = 0;
    bit          m_inflight = 0;
    int          m_last     = N - 1;
    int          m_owner    = 0;
    int          m_age      = 0;
    logic [31:0] m_res;
    logic        m_z, m_lt, m_ult;

    // Transaction timeline: granted at an edge, response visible from the
    // second edge onward, retired at the first edge where the owner accepts.
    initial forever begin
        int p;
        @(posedge clk);
        if (!rst_n) begin
            m_init     = 1;
            m_inflight = 0;
            m_age      = 0;
            m_last     = N - 1;
        end else if (m_init) begin
            if (!m_inflight) begin
                p = pick(req_valid, m_last);
                if (p >= 0) begin
                    m_inflight = 1;
                    m_owner    = p;
                    m_last     = p;
                    m_age      = 0;
                    alu_ref(c_arr[p], a_arr[p], b_arr[p], m_res, m_z, m_lt, m_ult);
                end
            end else if (m_age >= 1 && rsp_ready[m_owner]) begin
                m_inflight = 0;
            end else begin
                m_age++;
            end
        end
    end

    // Every-cycle comparison against the model.
    initial forever begin
        int            p;
        logic [N-1:0]  exp_ready;
        logic [N-1:0]  exp_rv;
        @(negedge clk);
        if (m_init) begin
            p         = pick(req_valid, m_last);
            exp_ready = '0;
            if (rst_n && !m_inflight && p >= 0) exp_ready[p] = 1'b1;
            exp_rv = '0;
            if (m_inflight && m_age >= 1) exp_rv[m_owner] = 1'b1;
            chk("req_ready", req_ready, exp_ready);
            chk("rsp_valid", rsp_valid, exp_rv);
            chk("busy", busy, m_inflight);
            chk("ready_onehot0", $onehot0(req_ready), 1);
            chk("rspv_onehot0", $onehot0(rsp_valid), 1);
            if (exp_rv != '0) begin
                chk("rsp_result", rsp_result, m_res);
                chk("rsp_zero", rsp_zero, m_z);
                chk("rsp_lt", rsp_less_than, m_lt);
                chk("rsp_ult", rsp_unsigned_less_than, m_ult);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_grant(input int i, input string nm);
        int n = 0;
        @(negedge clk);
        while (!req_ready[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(nm, req_ready[i], 1);
        step();
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_rsp(input int i, input string nm, input logic [31:0] er, input logic ez);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, rsp_valid[i], 1);
        chk({nm, "_result"}, rsp_result, er);
        chk({nm, "_zero"}, rsp_zero, ez);
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          glog [3];
        int          ng;
        bit          s0, s1;
        logic [N-1:0] hs;
        int          ops;
        int          waitc [N];
        int          maxw;

        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '1;
        for (int i = 0; i < N; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
            c_arr[i] = '0;
            waitc[i] = 0;
        end
        repeat (3) step();
        rst_n = 1'b1;

        // S1: single ADD, latency
        a_arr[0] = 32'd5; b_arr[0] = 32'd7; c_arr[0] = ALU_ADD; req_valid[0] = 1'b1;
        @(negedge clk); chk("s1_ready", req_ready, 4'b0001);
        step(); req_valid[0] = 1'b0;
        @(negedge clk); chk("s1_exec_rspv", rsp_valid, 4'b0000);
        step();
        @(negedge clk);
        chk("s1_rspv", rsp_valid, 4'b0001);
        chk("s1_result", rsp_result, 32'd12);
        chk("s1_zero", rsp_zero, 0);
        step();

        // S2: two requesters valid from reset, grant order 0,1,0
        rst_n = 1'b0;
        a_arr[0] = 32'd3; b_arr[0] = 32'd3;          c_arr[0] = ALU_SUB;
        a_arr[1] = 32'd1; b_arr[1] = 32'hFFFF_FFFF;  c_arr[1] = ALU_SLTU;
        req_valid = 4'b0011;
        repeat (2) step();
        rst_n = 1'b1;
        ng = 0; s0 = 0; s1 = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (req_ready != '0 && ng < 3) begin
                for (int j = 0; j < N; j++) if (req_ready[j]) glog[ng] = j;
                ng++;
            end
            if (rsp_valid == 4'b0001 && !s0) begin
                chk("s2_r0_result", rsp_result, 32'd0);
                chk("s2_r0_zero", rsp_zero, 1);
                s0 = 1;
            end
            if (rsp_valid == 4'b0010 && !s1) begin
                chk("s2_r1_result", rsp_result, 32'd1);
                chk("s2_r1_ult", rsp_unsigned_less_than, 1);
                s1 = 1;
            end
            step();
        end
        req_valid = '0;
        repeat (3) step();
        chk("s2_grant_count", ng, 3);
        chk("s2_grant0", glog[0], 0);
        chk("s2_grant1", glog[1], 1);
        chk("s2_grant2", glog[2], 0);
        chk("s2_both_seen", {s0, s1}, 2'b11);

        // S3: req1 SRA held for 5 cycles while req0 waits
        a_arr[1] = 32'h8000_0000; b_arr[1] = 32'd4; c_arr[1] = ALU_SRA;
        req_valid[1] = 1'b1; rsp_ready[1] = 1'b0;
        @(negedge clk); chk("s3_ready", req_ready, 4'b0010);
        step();
        req_valid[1] = 1'b0;
        a_arr[0] = 32'd10; b_arr[0] = 32'd20; c_arr[0] = ALU_ADD; req_valid[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("s3_blocked", req_ready, 4'b0000);
            if (k >= 1) begin
                chk("s3_hold_result", rsp_result, 32'hF800_0000);
                chk("s3_hold_valid", rsp_valid, 4'b0010);
            end
            step();
        end
        rsp_ready[1] = 1'b1;
        wait_grant(0, "s3_req0_grant");
        wait_rsp(0, "s3_req0", 32'd30, 1'b0);

        // S4: undefined op code
        a_arr[0] = 32'd9; b_arr[0] = 32'd9; c_arr[0] = 4'b1100; req_valid[0] = 1'b1;
        wait_grant(0, "s4_grant");
        wait_rsp(0, "s4", 32'd0, 1'b1);

        // S5: reset during EXEC of req1
        a_arr[1] = 32'd7; b_arr[1] = 32'd3; c_arr[1] = ALU_ADD; req_valid[1] = 1'b1;
        @(negedge clk); chk("s5_ready", req_ready, 4'b0010);
        step();
        req_valid[1] = 1'b0; rst_n = 1'b0;
        step();
        @(negedge clk);
        chk("s5_no_rsp", rsp_valid, 4'b0000);
        chk("s5_busy", busy, 0);
        step();
        rst_n = 1'b1; req_valid = 4'b0011;
        @(negedge clk); chk("s5_first_winner", req_ready, 4'b0001);
        step();
        req_valid = '0;
        repeat (4) step();

        // S6: random mixed traffic
        ops = 0; maxw = 0;
        for (int cyc = 0; cyc < 40000 && ops < 2000; cyc++) begin
            @(negedge clk);
            hs = req_ready & req_valid;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) waitc[i] = 0;
                else if (hs != '0 && req_valid[i]) begin
                    waitc[i]++;
                    if (waitc[i] > maxw) maxw = waitc[i];
                end
            end
            ops += $countones(hs);
            step();
            for (int i = 0; i < N; i++) begin
                if (hs[i]) req_valid[i] = 1'b0;
                if (!req_valid[i]) begin
                    waitc[i] = 0;
                    if ($urandom_range(0, 3) != 0) begin
                        c_arr[i] = 4'($urandom_range(0, 15));
                        a_arr[i] = $urandom;
                        case ($urandom_range(0, 2))
                            0:       b_arr[i] = $urandom;
                            1:       b_arr[i] = $urandom_range(0, 40);
                            default: b_arr[i] = a_arr[i];
                        endcase
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 49) == 0) begin
                    req_valid[i] = 1'b0;
                    waitc[i]     = 0;
                end
                rsp_ready[i] = ($urandom_range(0, 9) < 7);
            end
        end
        req_valid = '0; rsp_ready = '1;
        repeat (5) step();
        chk("s6_ops_done", ops >= 2000, 1);
        chk("s6_fairness", maxw <= N - 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_alu_arbiter.md
# cpu_alu_arbiter

Shares one `cpu_alu` instance between `NUM_REQ` requesters, such as the execute stage and the address/branch unit. Each requester has its own valid/ready request channel and valid/ready response channel. Requesters are granted round-robin, one operation at a time. Operands are registered, the ALU is evaluated, and the result and flags are held until the owning requester accepts them.

## Interface
Parameters:
- `XLEN`, 32, operand/result width.
- `NUM_REQ`, 2, number of requesters; legal range 2..4.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in NUM_REQ: per-requester request valid.
- `req_ready` out NUM_REQ: per-requester accept; at most one bit high.
- `req_operand_a` in NUM_REQ*XLEN: packed; requester i occupies bits [i*XLEN +: XLEN].
- `req_operand_b` in NUM_REQ*XLEN: packed, same layout as `req_operand_a`.
- `req_control` in NUM_REQ*4: packed ALU op codes, 4 bits per requester.
- `rsp_valid` out NUM_REQ: response valid; one-hot or zero.
- `rsp_ready` in NUM_REQ: per-requester response accept.
- `rsp_result` out XLEN: shared result bus, meaningful only for the requester whose `rsp_valid` bit is high.
- `rsp_zero` out 1: ALU zero flag of the held operation.
- `rsp_less_than` out 1: ALU signed less-than flag of the held operation.
- `rsp_unsigned_less_than` out 1: ALU unsigned less-than flag of the held operation.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP; state is held in `state_t`.
- IDLE:
  - Select a winner among the set `req_valid` bits, starting from `last_grant+1` mod NUM_REQ and searching upward with wrap.
  - `req_ready[winner]` = 1 combinationally; all other `req_ready` bits are 0.
  - On handshake: latch operand_a, operand_b and control into operand registers; set `owner`=winner and `last_grant`=winner; go to EXEC.
  - With no valid request, stay in IDLE; `last_grant` is unchanged.
- EXEC:
  - The ALU sees only the latched operands.
  - At the end of the cycle, capture result, zero, less_than and unsigned_less_than into response registers; go to RESP.
- RESP:
  - `rsp_valid[owner]`=1.
  - On `rsp_ready[owner]`, go to IDLE.
  - `rsp_ready` bits of non-owners are ignored.
  - Response registers are stable while waiting.
- `req_ready` is 0 in EXEC and RESP; requesters hold their requests and wait.
- ALU op encoding (4-bit):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
  - Shifts use operand_b[$clog2(XLEN)-1:0] as the shift amount.
  - SLT and SLTU produce a result of 0 or 1.
  - Codes 10..15 produce result 0 and `rsp_zero`=1. The less-than flags still reflect the operand compare. The operation is not trapped.
- Arithmetic wraps modulo 2^XLEN; there is no overflow indication.
- Arbitration is fair: a continuously requesting requester waits at most NUM_REQ-1 operations.

## Timing
- Reset values:
  - state=IDLE.
  - `last_grant`=NUM_REQ-1, so requester 0 wins first.
  - `owner`=0.
  - Operand and response registers = 0.
  - All `rsp_valid` = 0 and `busy` = 0.
- `req_ready` is combinational from `req_valid` and state, and is forced to 0 during reset.
- Latency: request handshake at cycle T, `rsp_valid` high from cycle T+2.
- Throughput: one operation per 3 cycles when the response is accepted immediately.
- A new request is accepted no earlier than the cycle after the response handshake.
- Simultaneous request and response from the same requester: the request is not accepted in RESP; it is granted in IDLE next cycle, subject to round-robin order.
- Reset asserted mid-operation (EXEC or RESP): the in-flight operation is dropped, no response is issued, and the FSM goes to IDLE on the next edge.
- A request withdrawn by deasserting `req_valid` before its handshake is never executed.

## Structure
- Shared package `cpu_alu_pkg` holds:
  - the `alu_op_t` enum for the ten codes, replacing the per-file ALU operation macros;
  - `state_t` {IDLE, EXEC, RESP};
  - localparam `ALU_CTRL_W`=4.
- Exactly one sub-module: an instance of `cpu_alu`, driven from the operand registers.
- The round-robin picker is written inline.

## Test plan
- Reset, then req0 requests ADD a=5, b=7 → `req_ready`=01; `rsp_valid`=01 two cycles later with result=12, zero=0.
- req0 and req1 both valid from reset: req0 SUB 3-3, req1 SLTU 1 vs 0xFFFFFFFF → grants in order 0,1,0. req0 result=0, zero=1; req1 result=1, unsigned_less_than=1.
- req1 issues SRA a=0x80000000 shamt=4 and holds `rsp_ready`=0 for 5 cycles → `rsp_result`=0xF8000000 stays stable; `req_ready`=00 throughout; req0 is blocked.
- req0 issues control 4'b1100 with a=9, b=9 → result=0, zero=1.
- `rst_n` dropped during EXEC of req1 → no `rsp_valid`; after release, req0 wins first; `busy`=0 at reset release.
- Random mixed traffic (NUM_REQ=4, 2000 ops) → every result matches the reference model, no requester starves, and `req_ready` and `rsp_valid` are each at-most-one-hot every cycle.
